mem_stage_access_unit: RTL

MIPS pipeline memory-stage controller that consumes the EX/MEM pipeline register outputs, drives the data-memory bus, and loads the MEM/WB pipeline register. It performs loads and stores over a variable-latency req/ack bus. While an access is outstanding it asserts `stall` so upstream pipeline registers hold. It inserts a writeback bubble for every stalled cycle.

---
 rtl/mem_stage_access_unit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_access_unit.sv
// mem_stage_access_unit
// MIPS memory-stage controller: takes the EX/MEM register outputs, runs loads
// and stores over a variable-latency req/ack data bus, stalls the upstream
// pipeline while an access is outstanding and loads the MEM/WB register.
// Every cycle in which the instruction does not retire puts a bubble
// (RegWrite/MemToReg cleared, other fields held) into MEM/WB.
//
// Optional build macro: MEM_ALIGN_CHECK_EN
//   defined   - a misaligned access is dropped in IDLE without touching the bus
//               or stalling; MEM/WB takes a bubble and out_Misaligned pulses.
//   undefined - address bits [1:0] are cleared on the bus, the access proceeds
//               and out_Misaligned is tied to 0.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | no bus activity; non-memory ops pass straight into MEM/WB
// ACCESS | mem_req high, waiting for mem_ack or for the timeout to expire

module mem_stage_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_Ctrl_RegWrite,
   input  logic        in_Ctrl_MemToReg,
   input  logic        in_Ctrl_MemRead,
   input  logic        in_Ctrl_MemWrite,
   input  logic [4:0]  in_Write_Register,
   input  logic [31:0] in_ALU_Result,
   input  logic [31:0] in_Write_Data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall,
   output logic        out_Ctrl_RegWrite,
   output logic        out_Ctrl_MemToReg,
   output logic [4:0]  out_Write_Register,
   output logic [31:0] out_Read_Data,
   output logic [31:0] out_ALU_Result,
   output logic        out_Bus_Error,
   output logic        out_Misaligned
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   // Last ACCESS cycle index before the access is abandoned.
   localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  tcnt;
   logic [7:0]  tcnt_nxt;
   logic        acc;
   logic        in_access;
   logic        ack_hit;
   logic        timeout;
   logic        wb_load;
   logic [31:0] wb_rdata;
   logic        bus_err_nxt;
`ifdef MEM_ALIGN_CHECK_EN
   logic        misaligned;
   logic        misal_nxt;
`endif

   assign acc = in_Ctrl_MemRead | in_Ctrl_MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = acc & (in_ALU_Result[1:0] != 2'b00);
`endif

   // Bus drive is qualified by reset so mem_req drops the instant reset asserts.
   assign in_access = reset & (state == S_ACCESS);
   assign mem_req   = in_access;
   assign mem_we    = in_access & in_Ctrl_MemWrite;
   assign mem_addr  = in_access ? {in_ALU_Result[31:2], 2'b00} : 32'h0;
   assign mem_wdata = in_access ? in_Write_Data : 32'h0;

   // Stall holds upstream registers until this instruction actually retires.
`ifdef MEM_ALIGN_CHECK_EN
   assign stall = reset & acc & ~(ack_hit | timeout)
                  & ~((state == S_IDLE) & misaligned);
`else
   assign stall = reset & acc & ~(ack_hit | timeout);
`endif

   // Next-state, timeout counter and MEM/WB load decisions.
   always_comb begin
      state_nxt   = state;
      tcnt_nxt    = tcnt;
      wb_load     = 1'b0;
      wb_rdata    = 32'h0;
      bus_err_nxt = 1'b0;
      ack_hit     = 1'b0;
      timeout     = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misal_nxt   = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (!acc) begin
               wb_load = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
            end else if (misaligned) begin
               misal_nxt = 1'b1;
`endif
            end else begin
               state_nxt = S_ACCESS;
               tcnt_nxt  = 8'h0;
            end
         end
         S_ACCESS: begin
            if (mem_ack) begin
               ack_hit   = 1'b1;
               wb_load   = 1'b1;
               // Combined read+write is treated as a store: no load data.
               wb_rdata  = in_Ctrl_MemWrite ? 32'h0 : mem_rdata;
               state_nxt = S_IDLE;
            end else if (tcnt == TCNT_LAST) begin
               timeout     = 1'b1;
               bus_err_nxt = 1'b1;
               state_nxt   = S_IDLE;
            end else begin
               tcnt_nxt = tcnt + 8'h1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register and timeout counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         tcnt  <= 8'h0;
      end else begin
         state <= state_nxt;
         tcnt  <= tcnt_nxt;
      end
   end

   // MEM/WB register: full load on retire, bubble (control bits only) otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_Ctrl_RegWrite  <= 1'b0;
         out_Ctrl_MemToReg  <= 1'b0;
         out_Write_Register <= 5'h0;
         out_Read_Data      <= 32'h0;
         out_ALU_Result     <= 32'h0;
      end else if (wb_load) begin
         out_Ctrl_RegWrite  <= in_Ctrl_RegWrite;
         out_Ctrl_MemToReg  <= in_Ctrl_MemToReg;
         out_Write_Register <= in_Write_Register;
         out_Read_Data      <= wb_rdata;
         out_ALU_Result     <= in_ALU_Result;
      end else begin
         out_Ctrl_RegWrite  <= 1'b0;
         out_Ctrl_MemToReg  <= 1'b0;
      end
   end

   // Bus-error pulse, one cycle after the timeout cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_Bus_Error <= 1'b0;
      end else begin
         out_Bus_Error <= bus_err_nxt;
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   // Misalignment pulse, one cycle after the rejected access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_Misaligned <= 1'b0;
      end else begin
         out_Misaligned <= misal_nxt;
      end
   end
`else
   assign out_Misaligned = 1'b0;
`endif

endmodule
